// File: rtl/seq_monitor_pkg.sv
// ---------------------------------------------------------------------------
// seq_monitor_pkg
//
// Shared definitions for the sequence-detector monitor:
//   - bit positions of the detector's one-hot states A..E
//   - monitor FSM state codes
//   - counter widths
//   - helpers that judge whether a detector sample is self-consistent
// ---------------------------------------------------------------------------
package seq_monitor_pkg;

    // Bit index of each detector state inside the 5-bit one-hot vector
    localparam int A_BIT = 0;
    localparam int B_BIT = 1;
    localparam int C_BIT = 2;
    localparam int D_BIT = 3;
    localparam int E_BIT = 4;

    localparam int STATE_W = 5;
    localparam int COUNT_W = 8;
    localparam int RUN_W   = 4;

    // One-hot code of the detector's idle/start state
    localparam logic [STATE_W-1:0] STATE_A = 5'b00001;

    // Monitor FSM state codes; code 3 is deliberately left unused
    typedef enum logic [1:0] {
        MON_WAIT  = 2'd0,
        MON_RUN   = 2'd1,
        MON_FAULT = 2'd2
    } mon_state_t;

    // True when exactly one bit of v is set
    function automatic logic is_one_hot(input logic [STATE_W-1:0] v);
        return (v != '0) && ((v & (v - 5'd1)) == '0);
    endfunction

    // A sample is consistent when the detector is in exactly one state and
    // its z output is high exactly in the two "run" states C and E
    function automatic logic sample_ok(input logic [STATE_W-1:0] st,
                                       input logic               zin);
        return is_one_hot(st) && (zin == (st[C_BIT] | st[E_BIT]));
    endfunction

endpackage

// File: rtl/seq_monitor_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//
// Saturating up-counter with clear and hold controls.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset, clears the count
//   inc        count up by one (sticks at all-ones)
//   clr        load zero (wins over inc)
//   hold       freeze the count (wins over clr and inc)
//   count      registered count value
//   count_next value the count will take at the next edge, for callers that
//              need to react to the new value in the same cycle
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    input  logic             hold,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_next
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Priority is hold > clr > inc; incrementing stops once every bit is set
    always_comb begin
        count_d = count_q;
        if (!hold) begin
            if (clr) begin
                count_d = '0;
            end else if (inc && (count_q != '1)) begin
                count_d = count_q + WIDTH'(1);
            end
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count      = count_q;
    assign count_next = count_d;

endmodule

// File: rtl/seq_monitor.sv
// ---------------------------------------------------------------------------
// seq_monitor
//
// Watches a "two or more consecutive equal w" sequence detector from the
// outside. Each edge it samples the detector's one-hot state and its z
// output, checks that the two agree, and gathers run statistics. Any
// inconsistent sample latches a sticky fault that only reset clears.
//
// Ports:
//   clk        sole clock, rising edge
//   reset      synchronous active-high reset
//   z          detector output (1 = run of equal w seen)
//   state      detector one-hot state {E,D,C,B,A}
//   c_count    cycles seen in state C (run of 0s), saturating at 255
//   e_count    cycles seen in state E (run of 1s), saturating at 255
//   run_len    current number of consecutive z=1 cycles, saturating at 15
//   max_run    largest run_len since reset
//   fault      sticky error flag, high exactly while mon_state is FAULT
//   mon_state  monitor FSM code (0=WAIT, 1=RUN, 2=FAULT) for debug LEDs
//
// All outputs are registered and reflect the sample taken one edge earlier.
// ---------------------------------------------------------------------------
module seq_monitor
    import seq_monitor_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               z,
    input  logic [STATE_W-1:0] state,
    output logic [COUNT_W-1:0] c_count,
    output logic [COUNT_W-1:0] e_count,
    output logic [RUN_W-1:0]   run_len,
    output logic [RUN_W-1:0]   max_run,
    output logic               fault,
    output logic [1:0]         mon_state
);

    mon_state_t         mon_state_q;
    mon_state_t         mon_state_d;
    logic               fault_q;
    logic               fault_d;
    logic [RUN_W-1:0]   max_run_q;
    logic [RUN_W-1:0]   max_run_d;

    logic               sample_bad;
    logic               update_en;
    logic [RUN_W-1:0]   run_len_next;

    // Only the run counter's look-ahead value is needed (for max_run)
    logic [COUNT_W-1:0] c_count_next_unused;
    logic [COUNT_W-1:0] e_count_next_unused;

    assign sample_bad = !sample_ok(state, z);

    // Monitor state register; fault and max_run live alongside it so every
    // output changes on the same edge as the state that governs it
    always_ff @(posedge clk) begin
        if (reset) begin
            mon_state_q <= MON_WAIT;
            fault_q     <= 1'b0;
            max_run_q   <= '0;
        end else begin
            mon_state_q <= mon_state_d;
            fault_q     <= fault_d;
            max_run_q   <= max_run_d;
        end
    end

    // Next-state logic: any bad sample sends us to FAULT, which is sticky.
    // WAIT only arms once the detector is seen back in its start state A.
    // The unused code 3 is treated as corruption and also lands in FAULT.
    always_comb begin
        mon_state_d = mon_state_q;
        case (mon_state_q)
            MON_WAIT: begin
                if (sample_bad) begin
                    mon_state_d = MON_FAULT;
                end else if (state == STATE_A) begin
                    mon_state_d = MON_RUN;
                end
            end
            MON_RUN: begin
                if (sample_bad) begin
                    mon_state_d = MON_FAULT;
                end
            end
            MON_FAULT: begin
                mon_state_d = MON_FAULT;
            end
            default: begin
                mon_state_d = MON_FAULT;
            end
        endcase
    end

    // Output/control logic. Counters advance only on a good sample taken
    // while already in RUN, so the bad sample that causes FAULT entry never
    // reaches them. Because a good sample is one-hot, a single bit test is
    // enough to recognise states C and E. max_run compares against the run
    // counter's next value so a new maximum shows up on the same edge.
    always_comb begin
        update_en = (mon_state_q == MON_RUN) && !sample_bad;
        fault_d   = (mon_state_d == MON_FAULT);
        max_run_d = max_run_q;
        if (update_en && (run_len_next > max_run_q)) begin
            max_run_d = run_len_next;
        end
    end

    sat_counter #(
        .WIDTH (COUNT_W)
    ) u_c_counter (
        .clk        (clk),
        .reset      (reset),
        .inc        (state[C_BIT]),
        .clr        (1'b0),
        .hold       (!update_en),
        .count      (c_count),
        .count_next (c_count_next_unused)
    );

    sat_counter #(
        .WIDTH (COUNT_W)
    ) u_e_counter (
        .clk        (clk),
        .reset      (reset),
        .inc        (state[E_BIT]),
        .clr        (1'b0),
        .hold       (!update_en),
        .count      (e_count),
        .count_next (e_count_next_unused)
    );

    sat_counter #(
        .WIDTH (RUN_W)
    ) u_run_counter (
        .clk        (clk),
        .reset      (reset),
        .inc        (z),
        .clr        (!z),
        .hold       (!update_en),
        .count      (run_len),
        .count_next (run_len_next)
    );

    assign max_run   = max_run_q;
    assign fault     = fault_q;
    assign mon_state = mon_state_q;

endmodule

// File: tb/tb_seq_monitor.sv
// ---------------------------------------------------------------------------
// tb_seq_monitor
//
// Directed bench for seq_monitor. The stimulus process drives one sample per
// cycle and, for interesting cycles, pushes the hand-computed output expected
// after that edge into a queue tagged with the edge number. A separate
// monitor process pops each entry after its edge and compares.
// ---------------------------------------------------------------------------
module tb_seq_monitor;

    localparam logic [1:0] WAIT  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FAULT = 2'd2;

    localparam logic [4:0] SA = 5'b00001;
    localparam logic [4:0] SB = 5'b00010;
    localparam logic [4:0] SC = 5'b00100;
    localparam logic [4:0] SD = 5'b01000;
    localparam logic [4:0] SE = 5'b10000;

    logic       clk = 1'b0;
    logic       reset;
    logic       z;
    logic [4:0] state;
    logic [7:0] c_count;
    logic [7:0] e_count;
    logic [3:0] run_len;
    logic [3:0] max_run;
    logic       fault;
    logic [1:0] mon_state;

    typedef struct {
        int         edge_no;
        string      name;
        logic [1:0] st;
        logic [7:0] c;
        logic [7:0] e;
        logic [3:0] rl;
        logic [3:0] mr;
    } exp_t;

    exp_t exp_q[$];
    int   cyc          = 0;
    int   stim_edge    = 0;
    int   tests_run    = 0;
    int   tests_failed = 0;

    seq_monitor dut (
        .clk       (clk),
        .reset     (reset),
        .z         (z),
        .state     (state),
        .c_count   (c_count),
        .e_count   (e_count),
        .run_len   (run_len),
        .max_run   (max_run),
        .fault     (fault),
        .mon_state (mon_state)
    );

    always #5 clk = ~clk;

    // Drive one sample on the falling edge; it is taken on the next rising edge
    task automatic applyStimulus(input logic rst, input logic [4:0] st, input logic zin);
        @(negedge clk);
        reset     = rst;
        state     = st;
        z         = zin;
        stim_edge = cyc + 1;
    endtask

    // Queue the outputs expected right after the most recently applied sample
    task automatic checkOutput(input string name, input logic [1:0] st,
                               input int c, input int e, input int rl, input int mr);
        exp_t x;
        x.edge_no = stim_edge;
        x.name    = name;
        x.st      = st;
        x.c       = 8'(c);
        x.e       = 8'(e);
        x.rl      = 4'(rl);
        x.mr      = 4'(mr);
        exp_q.push_back(x);
    endtask

    // Monitor: count edges, then compare every expectation due at this edge
    initial begin
        exp_t x;
        logic exp_fault;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            #1;
            while (exp_q.size() > 0 && exp_q[0].edge_no <= cyc) begin
                x         = exp_q.pop_front();
                exp_fault = (x.st == FAULT);
                tests_run = tests_run + 1;
                if (mon_state !== x.st || fault !== exp_fault || c_count !== x.c ||
                    e_count !== x.e || run_len !== x.rl || max_run !== x.mr ||
                    x.edge_no != cyc) begin
                    tests_failed = tests_failed + 1;
                    $display("[TB] FAIL %s @edge %0d: got st=%0d fault=%0b c=%0d e=%0d run=%0d max=%0d, expected st=%0d fault=%0b c=%0d e=%0d run=%0d max=%0d",
                             x.name, cyc, mon_state, fault, c_count, e_count, run_len, max_run,
                             x.st, exp_fault, x.c, x.e, x.rl, x.mr);
                end
            end
        end
    end

    // Stimulus with hand-computed expectations
    initial begin
        int waited;
        reset = 1'b1;
        state = 5'b00000;
        z     = 1'b0;

        // Reset wins even while a bad sample is presented
        applyStimulus(1'b1, 5'b00110, 1'b1);
        applyStimulus(1'b1, 5'b00110, 1'b1);
        checkOutput("reset_state", WAIT, 0, 0, 0, 0);

        // WAIT only leaves on state A
        applyStimulus(1'b0, SB, 1'b0); checkOutput("wait_hold_B", WAIT, 0, 0, 0, 0);
        applyStimulus(1'b0, SA, 1'b0); checkOutput("wait_to_run", RUN, 0, 0, 0, 0);

        // B,C,C,C with z=0,1,1,1
        applyStimulus(1'b0, SB, 1'b0); checkOutput("run_B", RUN, 0, 0, 0, 0);
        applyStimulus(1'b0, SC, 1'b1); checkOutput("run_C1", RUN, 1, 0, 1, 1);
        applyStimulus(1'b0, SC, 1'b1); checkOutput("run_C2", RUN, 2, 0, 2, 2);
        applyStimulus(1'b0, SC, 1'b1); checkOutput("run_C3", RUN, 3, 0, 3, 3);

        // D,E,E,B with z=0,1,1,0
        applyStimulus(1'b0, SD, 1'b0); checkOutput("run_D", RUN, 3, 0, 0, 3);
        applyStimulus(1'b0, SE, 1'b1); checkOutput("run_E1", RUN, 3, 1, 1, 3);
        applyStimulus(1'b0, SE, 1'b1); checkOutput("run_E2", RUN, 3, 2, 2, 3);
        applyStimulus(1'b0, SB, 1'b0); checkOutput("run_B_clear", RUN, 3, 2, 0, 3);

        // Long C run: c_count saturates at 255, run_len and max_run at 15
        for (int i = 1; i <= 300; i++) begin
            applyStimulus(1'b0, SC, 1'b1);
            if (i == 1 || i == 4 || i == 15 || i == 16 || i == 252 || i == 253 || i == 300) begin
                checkOutput($sformatf("sat_C%0d", i), RUN,
                            (3 + i > 255) ? 255 : 3 + i, 2,
                            (i > 15) ? 15 : i,
                            (i > 15) ? 15 : ((i > 3) ? i : 3));
            end
        end

        // run_len clears while max_run holds
        applyStimulus(1'b0, SA, 1'b0); checkOutput("run_A_clear", RUN, 255, 2, 0, 15);
        applyStimulus(1'b0, SE, 1'b1); checkOutput("run_E3", RUN, 255, 3, 1, 15);

        // Multi-hot state: fault, and the bad sample must not clear run_len
        applyStimulus(1'b0, 5'b00110, 1'b0); checkOutput("fault_multi_hot", FAULT, 255, 3, 1, 15);
        applyStimulus(1'b0, SE, 1'b1);       checkOutput("fault_sticky_E", FAULT, 255, 3, 1, 15);
        applyStimulus(1'b0, SA, 1'b0);       checkOutput("fault_sticky_A", FAULT, 255, 3, 1, 15);

        // Single-edge reset from FAULT
        applyStimulus(1'b1, SE, 1'b1); checkOutput("reset_from_fault", WAIT, 0, 0, 0, 0);

        // State C with z=0 is bad; neither c_count nor run_len may move
        applyStimulus(1'b0, SA, 1'b0); checkOutput("rerun", RUN, 0, 0, 0, 0);
        applyStimulus(1'b0, SE, 1'b1); checkOutput("rerun_E", RUN, 0, 1, 1, 1);
        applyStimulus(1'b0, SC, 1'b0); checkOutput("fault_C_z0", FAULT, 0, 1, 1, 1);

        // Bad samples while in WAIT
        applyStimulus(1'b1, SA, 1'b0);       checkOutput("reset2", WAIT, 0, 0, 0, 0);
        applyStimulus(1'b0, SA, 1'b1);       checkOutput("wait_bad_z", FAULT, 0, 0, 0, 0);
        applyStimulus(1'b1, SA, 1'b0);       checkOutput("reset3", WAIT, 0, 0, 0, 0);
        applyStimulus(1'b0, 5'b00000, 1'b0); checkOutput("wait_zero_state", FAULT, 0, 0, 0, 0);

        // Reset mid-run, then first sample judged under WAIT rules
        applyStimulus(1'b1, SA, 1'b0); checkOutput("reset4", WAIT, 0, 0, 0, 0);
        applyStimulus(1'b0, SA, 1'b0); checkOutput("run_again", RUN, 0, 0, 0, 0);
        applyStimulus(1'b0, SC, 1'b1); checkOutput("run_again_C", RUN, 1, 0, 1, 1);
        applyStimulus(1'b1, SC, 1'b1); checkOutput("reset_mid_run", WAIT, 0, 0, 0, 0);
        applyStimulus(1'b0, SC, 1'b1); checkOutput("post_reset_wait", WAIT, 0, 0, 0, 0);
        applyStimulus(1'b0, SA, 1'b0); checkOutput("post_reset_run", RUN, 0, 0, 0, 0);
        applyStimulus(1'b0, SC, 1'b1); checkOutput("post_reset_C", RUN, 1, 0, 1, 1);

        // Let the monitor drain the queue, with a bounded wait
        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited = waited + 1;
        end
        #2;
        if (exp_q.size() > 0) begin
            tests_run    = tests_run + 1;
            tests_failed = tests_failed + 1;
            $display("[TB] FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached, required completion");
        $fatal(1, "[TB] time limit reached");
    end

endmodule

// File: doc/seq_monitor.md
SEQ_MONITOR -- requirements
Module: seq_monitor

Interface
REQ-001 The block SHALL have these ports, clock and reset first:
- clk  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- z  input  1  detector output; 1 = two or more consecutive equal w.
- state  input  5  detector one-hot state {E,D,C,B,A}; A=bit0, B=bit1, C=bit2, D=bit3, E=bit4.
- c_count  output  8  cycles sampled in state C (run of 0s), saturating.
- e_count  output  8  cycles sampled in state E (run of 1s), saturating.
- run_len  output  4  current consecutive z=1 cycle count, saturating.
- max_run  output  4  largest run_len since reset.
- fault  output  1  sticky error flag.
- mon_state  output  2  monitor FSM state code, for debug LEDs.
REQ-002 One clock and a synchronous, active-high reset (named clk and reset) SHALL be the only timing and initialisation inputs; no other clock or asynchronous path.

Function
REQ-003 z and state SHALL be sampled every rising edge; all outputs SHALL be registered and reflect the sample taken one edge earlier (latency 1).
REQ-004 The monitor FSM SHALL have states WAIT=0, RUN=1, FAULT=2; code 3 is unused and SHALL recover to FAULT.
REQ-005 Validity check SHALL be: state has exactly one bit set AND z == state[2] | state[4]; a sample failing either is "bad".
REQ-006 WAIT: bad -> FAULT; state == 5'b00001 -> RUN; any other valid sample -> stay WAIT; counters hold.
REQ-007 RUN: bad -> FAULT; otherwise stay RUN and update counters per REQ-008..REQ-011 in the same edge.
REQ-008 In RUN, state == C SHALL increment c_count by 1, holding at 255.
REQ-009 In RUN, state == E SHALL increment e_count by 1, holding at 255.
REQ-010 In RUN, z = 1 SHALL increment run_len, holding at 15; z = 0 SHALL clear run_len to 0.
REQ-011 max_run SHALL load max(max_run, run_len_next) on the same edge run_len updates, so a new maximum appears with no extra cycle.
REQ-012 FAULT SHALL be sticky until reset: all counters freeze at their values from the edge before entry; fault = 1.
REQ-013 fault SHALL be 1 exactly when mon_state = FAULT.
REQ-014 On the edge entering FAULT, counters SHALL NOT update from the bad sample.

Reset
REQ-015 When reset = 1 at an edge, mon_state SHALL become WAIT and c_count, e_count, run_len, max_run and fault SHALL become 0, overriding any simultaneous update.
REQ-016 Reset asserted mid-run or in FAULT SHALL give the same result as power-up reset; the first post-reset sample is evaluated under WAIT rules.

Structure
REQ-017 A shared package SHALL hold the state-bit index constants (A..E), the FSM state codes, and the width constants (COUNT_W=8, RUN_W=4).
REQ-018 One sub-module, sat_counter (parameterised width; inc, clr, hold inputs; saturates at all-ones), SHALL implement c_count, e_count and run_len.

Verification
REQ-019 Reset, then state=00001 z=0 for 1 cycle -> mon_state=RUN, all counts 0.
REQ-020 From RUN, feed B,C,C,C (z=0,1,1,1) -> c_count=3, run_len=3, max_run=3, e_count=0.
REQ-021 Then feed D,E,E,B (z=0,1,1,0) -> e_count=2, run_len=0, max_run stays 3.
REQ-022 Feed C with z=1 for 300 cycles -> c_count=255, run_len=15, max_run=15, no fault.
REQ-023 In RUN, feed state=00110 or state=00100 with z=0 -> fault=1 next edge; counters hold; further valid input leaves fault=1.
REQ-024 In FAULT, assert reset for 1 edge -> fault=0, mon_state=WAIT, all counts 0.
